// File: rtl/dcache_pkg.sv
// Shared constants and FSM encoding for the direct-mapped data cache.
// Address split: tag | index | byte offset, over 32-bit blocks.
package dcache_pkg;

  localparam int ADDR_BITS   = 8;
  localparam int OFFSET_BITS = 2;
  localparam int INDEX_BITS  = 3;
  localparam int TAG_BITS    = ADDR_BITS - OFFSET_BITS - INDEX_BITS;
  localparam int BLOCK_BITS  = 32;
  localparam int BLOCK_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WRITE_BACK = 2'd1,
    FETCH      = 2'd2,
    UPDATE     = 2'd3
  } state_e;

  function automatic logic [7:0] get_byte(input logic [BLOCK_BITS-1:0] blk,
                                          input logic [OFFSET_BITS-1:0] off);
    return blk[{off, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Line storage for the data cache: data, tag, valid and dirty per line.
// One byte-write port for store hits and one block-fill port for refills.
module dcache_array #(
  parameter int INDEX_BITS = 3,
  parameter int TAG_BITS   = 3
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [INDEX_BITS-1:0] index_i,
  input  logic [1:0]            offset_i,
  input  logic                  byte_we_i,
  input  logic [7:0]            byte_wdata_i,
  input  logic                  fill_we_i,
  input  logic [TAG_BITS-1:0]   fill_tag_i,
  input  logic [31:0]           fill_data_i,
  output logic [31:0]           line_data_o,
  output logic [TAG_BITS-1:0]   line_tag_o,
  output logic                  line_valid_o,
  output logic                  line_dirty_o
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [31:0]         data_q [LINES];
  logic [TAG_BITS-1:0] tag_q  [LINES];
  logic [LINES-1:0]    valid_q;
  logic [LINES-1:0]    dirty_q;

  // NOTE: data/tag arrays have no reset so they map onto plain RAM; a cleared valid bit masks whatever they hold.
  always_ff @(posedge CLK) begin
    if (fill_we_i) begin
      data_q[index_i] <= fill_data_i;
      tag_q[index_i]  <= fill_tag_i;
    end else if (byte_we_i) begin
      data_q[index_i][{offset_i, 3'b000} +: 8] <= byte_wdata_i;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_we_i) begin
      valid_q[index_i] <= 1'b1;
      dirty_q[index_i] <= 1'b0;
    end else if (byte_we_i) begin
      dirty_q[index_i] <= 1'b1;
    end
  end

  assign line_data_o  = data_q[index_i];
  assign line_tag_o   = tag_q[index_i];
  assign line_valid_o = valid_q[index_i];
  assign line_dirty_o = dirty_q[index_i];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back, write-allocate data cache controller.
// Hits are served in IDLE; misses run write-back/fetch/update over the memory handshake.
module dcache_ctrl #(
  parameter int INDEX_BITS  = dcache_pkg::INDEX_BITS,
  parameter int BLOCK_BYTES = dcache_pkg::BLOCK_BYTES
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        read,
  input  logic        write,
  input  logic [7:0]  address,
  input  logic [7:0]  writedata,
  output logic [7:0]  readdata,
  output logic        busywait,
  output logic        mem_read,
  output logic        mem_write,
  output logic [5:0]  mem_address,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata,
  input  logic        mem_busywait
);

  localparam int TAG_BITS = 8 - dcache_pkg::OFFSET_BITS - INDEX_BITS;
  localparam int BLOCK_W  = 8 * BLOCK_BYTES;

  logic [TAG_BITS-1:0]               req_tag;
  logic [INDEX_BITS-1:0]             req_index;
  logic [dcache_pkg::OFFSET_BITS-1:0] req_offset;

  assign req_tag    = address[7 -: TAG_BITS];
  assign req_index  = address[dcache_pkg::OFFSET_BITS +: INDEX_BITS];
  assign req_offset = address[dcache_pkg::OFFSET_BITS-1:0];

  dcache_pkg::state_e state_q;
  logic               mem_read_q, mem_write_q;
  logic [5:0]         mem_address_q;
  logic [31:0]        mem_writedata_q;
  logic [BLOCK_W-1:0] fetched_q;
  logic [7:0]         readdata_q;

  logic [31:0]         line_data;
  logic [TAG_BITS-1:0] line_tag;
  logic                line_valid, line_dirty;
  logic                hit, req, in_idle, load_hit, byte_we, fill_we;
  logic [7:0]          line_byte;

  assign req       = read | write;
  assign in_idle   = (state_q == dcache_pkg::IDLE);
  assign hit       = line_valid && (line_tag == req_tag);
  assign load_hit  = in_idle && hit && read && !write;
  assign line_byte = dcache_pkg::get_byte(line_data, req_offset);

  // Reset wins over any same-edge store or refill so no line is left half-updated.
  assign byte_we = !RESET && in_idle && write && hit;
  assign fill_we = !RESET && (state_q == dcache_pkg::UPDATE);

  dcache_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_array (
    .CLK          (CLK),
    .RESET        (RESET),
    .index_i      (req_index),
    .offset_i     (req_offset),
    .byte_we_i    (byte_we),
    .byte_wdata_i (writedata),
    .fill_we_i    (fill_we),
    .fill_tag_i   (req_tag),
    .fill_data_i  (fetched_q),
    .line_data_o  (line_data),
    .line_tag_o   (line_tag),
    .line_valid_o (line_valid),
    .line_dirty_o (line_dirty)
  );

  // NOTE: all FSM state and registered outputs use non-blocking assignments so every reader sees pre-edge values.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q         <= dcache_pkg::IDLE;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_address_q   <= '0;
      mem_writedata_q <= '0;
      readdata_q      <= '0;
    end else begin
      case (state_q)
        dcache_pkg::IDLE: begin
          if (load_hit) readdata_q <= line_byte;
          if (req && !hit) begin
            if (line_dirty) begin
              state_q         <= dcache_pkg::WRITE_BACK;
              mem_write_q     <= 1'b1;
              mem_address_q   <= {line_tag, req_index};
              mem_writedata_q <= line_data;
            end else begin
              state_q       <= dcache_pkg::FETCH;
              mem_read_q    <= 1'b1;
              mem_address_q <= {req_tag, req_index};
            end
          end
        end
        dcache_pkg::WRITE_BACK: begin
          if (!mem_busywait) begin
            state_q       <= dcache_pkg::FETCH;
            mem_write_q   <= 1'b0;
            mem_read_q    <= 1'b1;
            mem_address_q <= {req_tag, req_index};
          end
        end
        dcache_pkg::FETCH: begin
          if (!mem_busywait) begin
            state_q    <= dcache_pkg::UPDATE;
            mem_read_q <= 1'b0;
            fetched_q  <= mem_readdata;
          end
        end
        dcache_pkg::UPDATE: state_q <= dcache_pkg::IDLE;
        default:            state_q <= dcache_pkg::IDLE;
      endcase
    end
  end

  assign busywait      = req && !(in_idle && hit);
  assign readdata      = load_hit ? line_byte : readdata_q;
  assign mem_read      = mem_read_q;
  assign mem_write     = mem_write_q;
  assign mem_address   = mem_address_q;
  assign mem_writedata = mem_writedata_q;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: directed CPU traffic against a latency-3 block memory model.
// Expected memory requests and load bytes are queued at issue and checked by a negedge monitor.
module tb_dcache_ctrl;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        read, write;
  logic [7:0]  address, writedata;
  logic [7:0]  readdata;
  logic        busywait;
  logic        mem_read, mem_write;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata = 32'h0;
  logic        mem_busywait = 1'b0;

  dcache_ctrl dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .read          (read),
    .write         (write),
    .address       (address),
    .writedata     (writedata),
    .readdata      (readdata),
    .busywait      (busywait),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .mem_busywait  (mem_busywait)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        wr;
    logic [5:0]  addr;
    logic [31:0] data;
  } mreq_t;

  localparam int MEM_LAT = 3;

  mreq_t       mem_q[$];
  logic [7:0]  rd_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] mem [64];
  int          mem_cnt  = 0;
  bit          mem_stall = 1'b0;
  logic        prev_rd = 1'b0, prev_wr = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_mem(input logic wr, input logic [5:0] a, input logic [31:0] d);
    mreq_t e;
    e.wr = wr; e.addr = a; e.data = d;
    mem_q.push_back(e);
  endtask

  // Block memory: MEM_LAT busy cycles per request, or busy forever while stalled.
  always @(negedge CLK) begin
    if (mem_read || mem_write) begin
      if (mem_stall || mem_cnt < MEM_LAT) begin
        mem_busywait = 1'b1;
        if (!mem_stall) mem_cnt++;
      end else begin
        mem_busywait = 1'b0;
        mem_cnt = 0;
        if (mem_write) mem[mem_address] = mem_writedata;
        else           mem_readdata = mem[mem_address];
      end
    end else begin
      mem_busywait = 1'b0;
      mem_cnt = 0;
    end
  end

  // Monitor: new memory requests and completed loads are compared against the queues.
  always @(negedge CLK) begin
    mreq_t e;
    if ((mem_read && !prev_rd) || (mem_write && !prev_wr)) begin
      if (mem_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_mem_req: got wr=%0b addr=%h expected none", mem_write, mem_address);
      end else begin
        e = mem_q.pop_front();
        check("mem_kind", {31'd0, mem_write}, {31'd0, e.wr});
        check("mem_exclusive", {31'd0, mem_read & mem_write}, 32'd0);
        check("mem_addr", {26'd0, mem_address}, {26'd0, e.addr});
        if (e.wr) check("mem_wdata", mem_writedata, e.data);
      end
    end
    prev_rd = mem_read;
    prev_wr = mem_write;
    if (read && !write && !busywait) begin
      if (rd_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_load: got readdata=%h expected none", readdata);
      end else begin
        check("load_data", {24'd0, readdata}, {24'd0, rd_q.pop_front()});
      end
    end
  end

  task automatic cpu_op(input logic rd, input logic wr, input logic [7:0] a,
                        input logic [7:0] wd, input int exp_stall, input string name);
    int stall = 0;
    bit done  = 1'b0;
    @(posedge CLK); #1;
    read = rd; write = wr; address = a; writedata = wd;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge CLK);
      if (!busywait) done = 1'b1;
      else           stall++;
    end
    check({name, "_done"}, {31'd0, done}, 32'd1);
    check({name, "_stall"}, stall, exp_stall);
    @(posedge CLK); #1;
    read = 1'b0; write = 1'b0;
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] exp, input int exp_stall, input string name);
    rd_q.push_back(exp);
    cpu_op(1'b1, 1'b0, a, 8'h00, exp_stall, name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[0] = 32'h44332211;
    mem[4] = 32'h87654321;
    mem[8] = 32'hDEADBEEF;
    mem[9] = 32'h0A0B0C0D;
    read = 1'b0; write = 1'b0; address = 8'h00; writedata = 8'h00;
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    @(negedge CLK);
    check("rst_mem_read", {31'd0, mem_read}, 32'd0);
    check("rst_mem_write", {31'd0, mem_write}, 32'd0);
    check("rst_mem_address", {26'd0, mem_address}, 32'd0);
    check("rst_mem_writedata", mem_writedata, 32'd0);
    check("rst_busywait", {31'd0, busywait}, 32'd0);
    check("rst_readdata", {24'd0, readdata}, 32'd0);

    // Clean miss, then hit in the same line with readdata held afterwards.
    push_mem(1'b0, 6'h00, 32'h0);
    load(8'h00, 8'h11, 6, "t1_clean_miss");
    load(8'h03, 8'h44, 0, "t2_hit");
    @(negedge CLK);
    check("t2_readdata_hold", {24'd0, readdata}, 32'h44);

    // Store hit dirties line 0; conflicting load writes it back then fetches.
    cpu_op(1'b0, 1'b1, 8'h01, 8'hAA, 0, "t3_store_hit");
    push_mem(1'b1, 6'h00, 32'h4433AA11);
    push_mem(1'b0, 6'h08, 32'h0);
    load(8'h21, 8'hBE, 10, "t3_dirty_miss");

    // Write miss on a clean line allocates, then the store lands and dirties it.
    push_mem(1'b0, 6'h01, 32'h0);
    cpu_op(1'b0, 1'b1, 8'h05, 8'h5C, 6, "t4_write_miss");
    load(8'h05, 8'h5C, 0, "t4_readback");
    push_mem(1'b1, 6'h01, 32'h00005C00);
    push_mem(1'b0, 6'h09, 32'h0);
    load(8'h25, 8'h0C, 10, "t4_evict");

    // Reset in the middle of a stalled fetch.
    mem_stall = 1'b1;
    push_mem(1'b0, 6'h04, 32'h0);
    @(posedge CLK); #1;
    read = 1'b1; address = 8'h10;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge CLK);
      if (mem_read) seen = 1'b1;
    end
    check("t5_fetch_started", {31'd0, seen}, 32'd1);
    repeat (3) @(negedge CLK);
    check("t5_stalled_read", {31'd0, mem_read}, 32'd1);
    check("t5_stalled_busy", {31'd0, busywait}, 32'd1);
    @(posedge CLK); #1;
    RESET = 1'b1; read = 1'b0;
    @(posedge CLK); #1;
    RESET = 1'b0;
    @(negedge CLK);
    check("t5_mem_read_dropped", {31'd0, mem_read}, 32'd0);
    check("t5_busywait_idle", {31'd0, busywait}, 32'd0);
    mem_stall = 1'b0;
    push_mem(1'b0, 6'h04, 32'h0);
    load(8'h10, 8'h21, 6, "t5_reread_miss");

    // read and write together act as a store.
    push_mem(1'b0, 6'h00, 32'h0);
    load(8'h00, 8'h11, 6, "t6_refill");
    cpu_op(1'b1, 1'b1, 8'h02, 8'h77, 0, "t6_rw_store");
    load(8'h02, 8'h77, 0, "t6_readback");
    push_mem(1'b1, 6'h00, 32'h4477AA11);
    push_mem(1'b0, 6'h08, 32'h0);
    load(8'h20, 8'hEF, 10, "t6_evict");

    repeat (2) @(negedge CLK);
    check("mem_q_drained", mem_q.size(), 32'd0);
    check("rd_q_drained", rd_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
Direct-mapped, write-back, write-allocate data cache between the CPU and the 32-bit-block data memory. It generates the `busywait` signal that stalls the CPU and the register file. It serves 8-bit loads and stores from the CPU. On misses it runs an FSM for block write-back and fetch over the memory-side busywait handshake.

Parameters:
- INDEX_BITS, 3, number of cache-line index bits (2^INDEX_BITS lines). Tag width = 8 - 2 - INDEX_BITS.
- BLOCK_BYTES, 4, bytes per line. Fixed at 4; only 32-bit memory blocks are supported.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RESET  in  1  reset, synchronous, active-high.
- read  in  1  CPU load request.
- write  in  1  CPU store request.
- address  in  8  CPU byte address: tag = [7:5], index = [4:2], offset = [1:0] (default parameters).
- writedata  in  8  CPU store data.
- readdata  out  8  CPU load data.
- busywait  out  1  CPU stall; high while the current request is not yet satisfied.
- mem_read  out  1  memory block read request.
- mem_write  out  1  memory block write request.
- mem_address  out  6  memory block address = {tag, index}.
- mem_writedata  out  32  block written back to memory.
- mem_readdata  in  32  block returned by memory.
- mem_busywait  in  1  memory stall; request complete on the first rising edge where it is low.

Behaviour:
- Storage per line:
  - data[31:0]; byte k occupies bits [8k+7:8k].
  - tag, valid, dirty.
- hit = valid[index] && (tag[index] == address tag).
- Reset, synchronous: on a rising edge with RESET = 1:
  - all valid and dirty bits cleared; state = IDLE.
  - Data and tag arrays are left unchanged.
- Reset values of outputs:
  - mem_read = 0, mem_write = 0, mem_address = 0, mem_writedata = 0.
  - busywait = 0, readdata = 0.
- RESET overrides every state, including mid-transaction. The memory request drops in the cycle after the reset edge. A partially fetched block is never marked valid.
- Request rules:
  - If read and write are both high, the request is treated as a write.
  - The CPU holds address, writedata and request stable while busywait = 1.
- busywait is combinational: (read | write) && !(state == IDLE && hit). It is low whenever no request is present.
- States: IDLE, WRITE_BACK, FETCH, UPDATE.
- IDLE:
  - Read hit: readdata = selected byte, combinational, same cycle. busywait = 0. No state change.
  - Write hit: at the next edge, the byte at offset takes writedata and dirty is set. busywait = 0, so the store is single-cycle.
  - Miss with dirty[index] = 1: go to WRITE_BACK. Miss with dirty[index] = 0: go to FETCH.
  - No request: stay in IDLE. readdata holds its last value.
- WRITE_BACK:
  - Drives mem_write = 1, mem_address = {stored tag, index}, mem_writedata = line data.
  - At the first edge with mem_busywait = 0: go to FETCH.
- FETCH:
  - Drives mem_read = 1, mem_address = {request tag, index}.
  - At the first edge with mem_busywait = 0: capture mem_readdata and go to UPDATE.
- UPDATE:
  - At the edge: line data = captured block, tag = request tag, valid = 1, dirty = 0. Go to IDLE.
  - The request then hits in IDLE. A write miss completes there as a write hit and sets dirty.
- mem_read and mem_write are never high simultaneously. Both are 0 in IDLE and UPDATE.
- Minimum miss latency:
  - Clean miss: FETCH(n) + UPDATE(1) + IDLE hit.
  - Dirty miss: adds the WRITE_BACK cycles.
- If mem_busywait is held high, the FSM waits indefinitely in WRITE_BACK or FETCH with outputs stable.

Decomposition:
- Shared package contents:
  - FSM state encoding: IDLE = 2'd0, WRITE_BACK = 2'd1, FETCH = 2'd2, UPDATE = 2'd3.
  - Address field widths/offsets: TAG_BITS, INDEX_BITS, OFFSET_BITS.
  - Block width constant: 32.
- One natural sub-module, dcache_array: the data/tag/valid/dirty storage with byte-write and block-fill ports. The FSM stays in dcache_ctrl.

Test Plan:
1. RESET high for 1 edge, then read address 0x00; memory returns 0x44332211 after 3 busy cycles -> mem_read = 1 with mem_address = 0x00, then UPDATE, then busywait = 0 with readdata = 0x11.
2. Following test 1, read 0x03 -> hit, busywait stays 0, readdata = 0x44 in the same cycle, no memory activity.
3. Write 0x01 with data 0xAA (hit), then read 0x21 -> mem_write = 1 with mem_address = 0x00 and mem_writedata = 0x4433AA11, then mem_read with mem_address = 0x08.
4. Write miss at 0x05, data 0x5C, line clean; memory returns 0x00000000 -> fetch from mem_address = 0x01, then byte 1 of line 1 = 0x5C and dirty = 1. A later eviction writes back 0x00005C00.
5. RESET asserted during FETCH with mem_busywait high -> state IDLE, mem_read = 0 after the reset edge. A re-read of the same address misses again (valid = 0).
6. Set read = write = 1 at 0x02, data 0x77 on a hit line -> treated as a write; byte 2 = 0x77 and busywait = 0.
